// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS controller.
//   - FSM state codes (4-bit)
//   - opcode (IR[31:26]) and R-type func (IR[5:0]) values
//   - datapath select codes: ALUop, PCSrc, ALUSrcB, MemtoReg
package mc_pkg;

  // FSM states
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_REX    = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_IEX    = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_JR     = 4'd13;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type func codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BRT = 2'b11;

  // Register write-back source select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_func_decoder.sv
// alu_func_decoder: maps an R-type func field to an ALU operation.
//   func_i  [5:0]  IR[5:0]
//   aluop_o [2:0]  ALU operation for the REX state
//   valid_o        1 when func is one of the supported ALU functions
// jr (func 08h) is not an ALU function and reports valid_o=0; the
// controller recognises it separately.
module alu_func_decoder
  import mc_pkg::*;
(
  input  logic [5:0] func_i,
  output logic [2:0] aluop_o,
  output logic       valid_o
);

  always_comb begin
    aluop_o = ALU_AND;
    valid_o = 1'b1;
    case (func_i)
      FN_ADD:  aluop_o = ALU_ADD;
      FN_SUB:  aluop_o = ALU_SUB;
      FN_AND:  aluop_o = ALU_AND;
      FN_OR:   aluop_o = ALU_OR;
      FN_SLT:  aluop_o = ALU_SLT;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multi-cycle MIPS datapath
// (shared memory, IR/MDR/A/B/ALUOut registers, word-addressed PC).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opc, func           IR[31:26], IR[5:0]
//   zero                ALU zero flag (used only by the branch state)
//   mem_ready           memory access complete (only with MC_MEM_WAIT_EN)
//   IorD..RegWrite      datapath strobes/selects, decoded from the state
//   illegal             one-cycle pulse when DECODE sees an unknown opc/func
//   instret             retired instruction counter (wraps)
//   bus_err             sticky memory-timeout flag
//   state_dbg_o         current FSM state, for observation
// Build option: define MC_MEM_WAIT_EN to let FETCH/MEMRD/MEMWR stretch until
// mem_ready, with a timeout of MEM_TIMEOUT not-ready cycles per access.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int INSTRET_W   = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opc,
  input  logic [5:0]           func,
  input  logic                 zero,
`ifdef MC_MEM_WAIT_EN
  input  logic                 mem_ready,
`endif
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic [1:0]           PCSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUop,
  output logic                 RegDst,
  output logic                 Jal,
  output logic [1:0]           MemtoReg,
  output logic                 RegWrite,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret,
  output logic                 bus_err,
  output logic [3:0]           state_dbg_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  // Memory handshake: the controller presents a request by sitting in a
  // memory state with MemRead/MemWrite high; the access completes in the
  // cycle mem_ready is 1, and only that cycle commits IRWrite/PCWrite/MemWrite.
  // Without the wait option every access completes in its first cycle.
  logic mem_rdy;
`ifdef MC_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  logic [3:0]           state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 bus_err_q, bus_err_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 illegal_c;
  logic                 in_mem, timeout, retire;
  logic [2:0]           alu_func_op;
  logic                 alu_func_ok;

  alu_func_decoder u_alu_func_decoder (
    .func_i  (func),
    .aluop_o (alu_func_op),
    .valid_o (alu_func_ok)
  );

  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // The wait counter holds the number of not-ready cycles already spent on
  // this access; the MEM_TIMEOUT-th not-ready cycle abandons it.
  assign timeout = in_mem && !mem_rdy && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Next state
  always_comb begin
    state_d   = state_q;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_RTYPE: begin
            if (alu_func_ok)        state_d = S_REX;
            else if (func == FN_JR) state_d = S_JR;
            else begin
              state_d   = S_FETCH;
              illegal_c = 1'b1;
            end
          end
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_IEX;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opc == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_REX:    state_d = S_RWB;
      S_IEX:    state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FETCH;
  end

  // An instruction retires when it re-enters FETCH from its last state;
  // illegal-opcode bounces (from DECODE), FETCH stalls and timeouts do not count.
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                  (state_q != S_DECODE) && !timeout;

  always_comb begin
    instret_d  = retire ? instret_q + INSTRET_W'(1) : instret_q;
    bus_err_d  = bus_err_q | timeout;
    wait_cnt_d = (in_mem && !mem_rdy && !timeout) ? wait_cnt_q + WAIT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      instret_q  <= '0;
      bus_err_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      instret_q  <= instret_d;
      bus_err_q  <= bus_err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Output decode from the state register (plus zero in BRANCH and the
  // IR fields that select the ALU operation).
  always_comb begin
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = PCSRC_ALU;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REG;
    ALUop    = ALU_AND;
    RegDst   = 1'b0;
    Jal      = 1'b0;
    MemtoReg = M2R_ALUOUT;
    RegWrite = 1'b0;
    illegal  = illegal_c;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
        ALUSrcB = SRCB_ONE;
        ALUop   = ALU_ADD;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BRT;
        ALUop   = ALU_ADD;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUop   = ALU_ADD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = M2R_MDR;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = mem_rdy;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUop   = alu_func_op;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        MemtoReg = M2R_ALUOUT;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCWrite = (opc == OP_BEQ) ? zero : ~zero;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUop   = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCWrite = 1'b1;
      end
      S_JAL: begin
        Jal      = 1'b1;
        MemtoReg = M2R_PC;
        RegWrite = 1'b1;
        PCSrc    = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      S_JR: begin
        PCSrc   = PCSRC_RS;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 2'b00;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUop    = 3'b000;
      RegDst   = 1'b0;
      Jal      = 1'b0;
      MemtoReg = 2'b00;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign instret     = instret_q;
  assign bus_err     = bus_err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction sequences. For every
// cycle the driver pushes the hand-written expected output row into exp_q;
// a monitor on the falling edge pops one row per cycle and compares it with
// the DUT outputs. Define MC_MEM_WAIT_EN to also exercise memory stalls.
module tb_multicycle_controller;

  localparam int VW = 40;

  localparam logic [3:0] T_FETCH  = 4'd0;
  localparam logic [3:0] T_DECODE = 4'd1;
  localparam logic [3:0] T_MEMADR = 4'd2;
  localparam logic [3:0] T_MEMRD  = 4'd3;
  localparam logic [3:0] T_MEMWB  = 4'd4;
  localparam logic [3:0] T_MEMWR  = 4'd5;
  localparam logic [3:0] T_REX    = 4'd6;
  localparam logic [3:0] T_RWB    = 4'd7;
  localparam logic [3:0] T_BRANCH = 4'd8;
  localparam logic [3:0] T_IEX    = 4'd9;
  localparam logic [3:0] T_IWB    = 4'd10;
  localparam logic [3:0] T_JUMP   = 4'd11;
  localparam logic [3:0] T_JAL    = 4'd12;
  localparam logic [3:0] T_JR     = 4'd13;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opc, func;
  logic        zero;
`ifdef MC_MEM_WAIT_EN
  logic        mem_ready;
`endif
  logic        IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic [1:0]  PCSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUop;
  logic        RegDst, Jal;
  logic [1:0]  MemtoReg;
  logic        RegWrite, illegal;
  logic [15:0] instret;
  logic        bus_err;
  logic [3:0]  state_dbg;

  multicycle_controller #(.INSTRET_W(16), .MEM_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .opc         (opc),
    .func        (func),
    .zero        (zero),
`ifdef MC_MEM_WAIT_EN
    .mem_ready   (mem_ready),
`endif
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCSrc       (PCSrc),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUop       (ALUop),
    .RegDst      (RegDst),
    .Jal         (Jal),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .illegal     (illegal),
    .instret     (instret),
    .bus_err     (bus_err),
    .state_dbg_o (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard
  logic [VW-1:0] exp_q[$];
  logic [15:0]   exp_ir = '0;
  logic          exp_be = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            row    = 0;

  logic [VW-1:0] act;
  assign act = {state_dbg, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA,
                ALUSrcB, ALUop, RegDst, Jal, MemtoReg, RegWrite, illegal, bus_err, instret};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [VW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL row%0d state=%0d got=%h want=%h", row, state_dbg, act, e);
      end
      row++;
    end
  end

  // Driver tasks
  task automatic wr_row(input logic [3:0] st, input logic iord, input logic mr,
                        input logic mw, input logic irw, input logic pcw,
                        input logic [1:0] pcsrc, input logic srca, input logic [1:0] srcb,
                        input logic [2:0] aluop, input logic rdst, input logic jal,
                        input logic [1:0] m2r, input logic rw, input logic ill);
    exp_q.push_back({st, iord, mr, mw, irw, pcw, pcsrc, srca, srcb, aluop, rdst, jal,
                     m2r, rw, ill, exp_be, exp_ir});
  endtask

  task automatic idle_row(input logic [3:0] st);
    wr_row(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000,
           1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic fetch_decode(input logic ill);
    wr_row(T_FETCH,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 3'b010,
           1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    wr_row(T_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 3'b010,
           1'b0, 1'b0, 2'b00, 1'b0, ill);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] o, input logic [5:0] f);
    opc  = o;
    func = f;
    zero = 1'($urandom_range(0, 1));
  endtask

  task automatic rtype(input logic [5:0] f, input logic [2:0] aluop);
    set_ir(6'h00, f);
    fetch_decode(1'b0);
    wr_row(T_REX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, aluop,
           1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    wr_row(T_RWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000,
           1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    run(4);
    exp_ir++;
  endtask

  task automatic branch(input logic [5:0] o, input logic z, input logic pcw);
    set_ir(o, 6'h00);
    zero = z;
    fetch_decode(1'b0);
    wr_row(T_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0, pcw, 2'b01, 1'b1, 2'b00, 3'b110,
           1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    run(3);
    exp_ir++;
  endtask

  task automatic itype(input logic [5:0] o, input logic [2:0] aluop);
    set_ir(o, 6'h15);
    fetch_decode(1'b0);
    wr_row(T_IEX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, aluop,
           1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    wr_row(T_IWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000,
           1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    run(4);
    exp_ir++;
  endtask

  task automatic jump();
    set_ir(6'h02, 6'h11);
    fetch_decode(1'b0);
    wr_row(T_JUMP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 3'b000,
           1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    run(3);
    exp_ir++;
  endtask

  task automatic bad(input logic [5:0] o, input logic [5:0] f);
    set_ir(o, f);
    fetch_decode(1'b1);
    run(2);
  endtask

  task automatic mem_prefix(input logic [5:0] o);
    set_ir(o, 6'h2C);
    fetch_decode(1'b0);
    wr_row(T_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b010,
           1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic fetch_stall_rows(input int n);
    for (int i = 0; i < n; i++)
      wr_row(T_FETCH, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b010,
             1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    rst  = 1'b1;
    opc  = 6'h00;
    func = 6'h00;
    zero = 1'b0;
`ifdef MC_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    // Reset: FETCH, counters clear, strobes held low while rst is high.
    @(posedge clk); #1;
    idle_row(T_FETCH);
    run(1);
    rst = 1'b0;

    // R-type ALU operations
    rtype(6'h20, 3'b010);
    rtype(6'h22, 3'b110);
    rtype(6'h25, 3'b001);
    rtype(6'h2A, 3'b111);

    // lw: FETCH, DECODE, MEMADR, MEMRD, MEMWB
    mem_prefix(6'h23);
    wr_row(T_MEMRD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000,
           1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    wr_row(T_MEMWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000,
           1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    run(5);
    exp_ir++;

    // sw: FETCH, DECODE, MEMADR, MEMWR
    mem_prefix(6'h2B);
    wr_row(T_MEMWR, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000,
           1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    run(4);
    exp_ir++;

    // Branches: beq takes on zero, bne on ~zero
    branch(6'h04, 1'b1, 1'b1);
    branch(6'h04, 1'b0, 1'b0);
    branch(6'h05, 1'b0, 1'b1);
    branch(6'h05, 1'b1, 1'b0);

    // Immediate ALU ops
    itype(6'h08, 3'b010);
    itype(6'h0A, 3'b111);

    // j, jal, jr
    jump();
    set_ir(6'h03, 6'h00);
    fetch_decode(1'b0);
    wr_row(T_JAL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 3'b000,
           1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    run(3);
    exp_ir++;
    set_ir(6'h00, 6'h08);
    fetch_decode(1'b0);
    wr_row(T_JR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 3'b000,
           1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    run(3);
    exp_ir++;

    // Illegal opcode and illegal R-type func: pulse, refetch, no retire
    bad(6'h3F, 6'h20);
    bad(6'h00, 6'h3F);
    rtype(6'h24, 3'b000);

    // Reset while in MEMRD: strobes low immediately, then FETCH with cleared counter
    mem_prefix(6'h23);
    run(3);
    rst = 1'b1;
    idle_row(T_MEMRD);
    run(1);
    exp_ir = '0;
    exp_be = 1'b0;
    idle_row(T_FETCH);
    run(1);
    rst = 1'b0;
    rtype(6'h20, 3'b010);

`ifdef MC_MEM_WAIT_EN
    // FETCH stalled 3 cycles: commits only on the ready cycle
    set_ir(6'h02, 6'h00);
    mem_ready = 1'b0;
    fetch_stall_rows(3);
    run(3);
    mem_ready = 1'b1;
    jump();

    // FETCH stalled 16 cycles: timeout on the 15th, sticky bus_err, refetch
    set_ir(6'h02, 6'h00);
    mem_ready = 1'b0;
    fetch_stall_rows(15);
    run(15);
    exp_be = 1'b1;
    fetch_stall_rows(1);
    run(1);
    mem_ready = 1'b1;
    jump();
`endif

    // All expected rows must have been consumed
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
